// File: rtl/serial_addsub_4_pkg.sv
// Shared constants and state encoding for the bit-serial adder/subtractor.
package serial_addsub_4_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_4_full_adder.sv
// One-bit full adder; the per-cycle bit cell of the serial datapath.
module full_adder_1bit (
  input  logic A,
  input  logic B,
  input  logic C_IN,
  output logic SUM,
  output logic C_OUT
);

  assign SUM   = A ^ B ^ C_IN;
  assign C_OUT = (A & B) | (C_IN & (A ^ B));

endmodule

// File: rtl/serial_addsub_4.sv
// Bit-serial add/subtract, LSB first, one bit per cycle through a single full adder.
// Handshake: an operation is accepted on a rising edge where READY=1 and START=1;
// DONE pulses for one cycle when RESULT/C_OUT/OVF are valid, and they hold until the next accept.
module serial_addsub_4
  import serial_addsub_4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             C_OUT,
  output logic             OVF,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               sub_q, sub_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fa_sum, fa_cout;
  logic               last_bit;

  // Subtraction is A + ~B + 1: B is inverted here and the +1 comes from the carry preset.
  full_adder_1bit u_fa (
    .A    (a_q[0]),
    .B    (b_q[0] ^ sub_q),
    .C_IN (carry_q),
    .SUM  (fa_sum),
    .C_OUT(fa_cout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          sub_d   = SUB;
          cnt_d   = '0;
          carry_d = SUB;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = FINISH;
          // Carry into the MSB is the current carry register; carry out is the adder's.
          ovf_d   = carry_q ^ fa_cout;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign READY     = (state_q == IDLE);
  assign DONE      = (state_q == FINISH);
  assign RESULT    = res_q;
  assign C_OUT     = carry_q;
  assign OVF       = ovf_q;
  assign dbg_state = state_q;

endmodule
